// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute, data-memory and writeback bus of the load/store unit
// Purpose: bundles every non-clock signal of the load/store unit.
// Ports:
//   in_*        execute -> unit op handshake (in_ready is the unit's accept)
//   mem_*       unit -> data memory control, funct3, address, write data;
//               mem_rd_data returns already-extended load data
//   wb_*        unit -> register-file writeback handshake
//   store_done  one-cycle pulse when a store is issued
//   exc_*       one-cycle exception pulse with cause and faulting address
// Modports: slave is the load/store unit, master is its environment.
interface load_store_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic [6:0]  mem_dp_ctrl;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rd_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_addr, in_wdata, in_rd,
    input  mem_rd_data, wb_ready,
    output in_ready, mem_dp_ctrl, mem_funct3, mem_addr, mem_wdata,
    output wb_valid, wb_rd, wb_data, store_done, exc_valid, exc_cause, exc_addr
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_addr, in_wdata, in_rd,
    output mem_rd_data, wb_ready,
    input  in_ready, mem_dp_ctrl, mem_funct3, mem_addr, mem_wdata,
    input  wb_valid, wb_rd, wb_data, store_done, exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: checks, memory sequencing, held writeback
// Purpose: accepts one load/store/bypass op at a time from execute, checks
//   funct3 legality, alignment and range, drives the data-memory port, captures
//   load data and holds a writeback transaction until the register file takes it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    load_store_unit_if.slave (in_*, mem_*, wb_*, store_done, exc_*)
// All outputs are registered; control outputs are decoded from the next state.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64,
  parameter logic [6:0]  OP_LOAD   = 7'b0000011,
  parameter logic [6:0]  OP_STORE  = 7'b0100011
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_LOAD_REQ,
    S_LOAD_CAP,
    S_WB,
    S_EXC
  } state_t;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic [6:0]  mem_dp_ctrl_q, mem_dp_ctrl_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        store_done_q, store_done_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        is_load;
  logic        is_store;
  logic        f3_legal;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  size_m1;
  logic [32:0] last_byte;

  assign is_load  = (bus.in_opcode == OP_LOAD);
  assign is_store = (bus.in_opcode == OP_STORE);

  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end else begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] selects byte/half/word; only consulted once funct3 is legal.
  always_comb begin
    size_m1 = 2'd0;
    case (bus.in_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  assign misaligned = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                      ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));

  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign last_byte    = {1'b0, bus.in_addr} + {31'b0, size_m1};
  assign out_of_range = (last_byte >= 33'(MEM_BYTES));

  always_comb begin
    state_d      = state_q;
    mem_funct3_d = mem_funct3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    exc_cause_d  = exc_cause_q;
    exc_addr_d   = exc_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mem_funct3_d = bus.in_funct3;
          mem_addr_d   = bus.in_addr;
          mem_wdata_d  = bus.in_wdata;
          if (is_load || is_store) begin
            exc_addr_d = bus.in_addr;
            if (!f3_legal) begin
              exc_cause_d = CAUSE_FUNCT3;
              state_d     = S_EXC;
            end else if (misaligned) begin
              exc_cause_d = CAUSE_MISALIGN;
              state_d     = S_EXC;
            end else if (out_of_range) begin
              exc_cause_d = CAUSE_RANGE;
              state_d     = S_EXC;
            end else if (is_load) begin
              wb_rd_d = bus.in_rd;
              state_d = S_LOAD_REQ;
            end else begin
              state_d = S_STORE;
            end
          end else begin
            // Bypass: the ALU result travels straight to writeback.
            wb_rd_d   = bus.in_rd;
            wb_data_d = bus.in_addr;
            state_d   = S_WB;
          end
        end
      end
      S_STORE:    state_d = S_IDLE;
      S_LOAD_REQ: state_d = S_LOAD_CAP;
      S_LOAD_CAP: begin
        wb_data_d = bus.mem_rd_data;
        state_d   = S_WB;
      end
      S_WB: begin
        if (bus.wb_ready) begin
          state_d = S_IDLE;
        end
      end
      S_EXC:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Registered control outputs follow the state being entered.
  always_comb begin
    in_ready_d    = (state_d == S_IDLE);
    store_done_d  = (state_d == S_STORE);
    exc_valid_d   = (state_d == S_EXC);
    wb_valid_d    = (state_d == S_WB);
    mem_dp_ctrl_d = 7'd0;
    if (state_d == S_STORE) begin
      mem_dp_ctrl_d = OP_STORE;
    end else if (state_d == S_LOAD_REQ) begin
      mem_dp_ctrl_d = OP_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      mem_dp_ctrl_q <= 7'd0;
      mem_funct3_q  <= 3'd0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'd0;
      store_done_q  <= 1'b0;
      exc_valid_q   <= 1'b0;
      exc_cause_q   <= 2'd0;
      exc_addr_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      mem_dp_ctrl_q <= mem_dp_ctrl_d;
      mem_funct3_q  <= mem_funct3_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      store_done_q  <= store_done_d;
      exc_valid_q   <= exc_valid_d;
      exc_cause_q   <= exc_cause_d;
      exc_addr_q    <= exc_addr_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mem_dp_ctrl = mem_dp_ctrl_q;
  assign bus.mem_funct3  = mem_funct3_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.store_done  = store_done_q;
  assign bus.exc_valid   = exc_valid_q;
  assign bus.exc_cause   = exc_cause_q;
  assign bus.exc_addr    = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with memory model
module tb_load_store_unit;
  localparam int         MEM_BYTES = 64;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam int K_WB = 0, K_EXC = 1, K_STORE = 2, K_LOAD = 3;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic [2:0]  f3;
  } exp_t;

  logic clk;
  logic rst_n;
  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  bit   wb_hold = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd4:    return {24'd0, raw[7:0]};
      3'd5:    return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] dmem_raw(input logic [31:0] a);
    logic [31:0] r;
    longint      idx;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      idx = longint'({32'd0, a}) + i;
      if (idx < MEM_BYTES) r[8*i +: 8] = dmem[int'(idx)];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_raw(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (int'(a) + i < MEM_BYTES) r[8*i +: 8] = ref_mem[int'(a) + i];
    end
    return r;
  endfunction

  // Reference classification straight from the access rules.
  function automatic void classify(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                                   output int kind, output logic [1:0] cause);
    longint ua;
    longint sz;
    bit     legal;
    ua    = longint'({32'd0, a});
    cause = 2'd0;
    if (op != OP_LOAD && op != OP_STORE) begin
      kind = K_WB;
      return;
    end
    if (op == OP_LOAD) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else               legal = (f3 inside {3'd0, 3'd1, 3'd2});
    sz = longint'(1) << f3[1:0];
    if (!legal) begin
      kind = K_EXC; cause = 2'b11;
    end else if (ua % sz != 0) begin
      kind = K_EXC; cause = 2'b01;
    end else if (ua + sz - 1 >= MEM_BYTES) begin
      kind = K_EXC; cause = 2'b10;
    end else begin
      kind = (op == OP_LOAD) ? K_LOAD : K_STORE;
    end
  endfunction

  // Data memory responder: sees the port at mid-cycle, acts just after the edge.
  initial begin
    logic [6:0]  c;
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  f;
    bus.mem_rd_data = 32'd0;
    forever begin
      @(negedge clk);
      c = bus.mem_dp_ctrl; a = bus.mem_addr; w = bus.mem_wdata; f = bus.mem_funct3;
      @(posedge clk);
      #1;
      if (c == OP_STORE) begin
        for (int i = 0; i < (1 << f[1:0]); i++) begin
          if (longint'({32'd0, a}) + i < MEM_BYTES) dmem[int'(a) + i] = w[8*i +: 8];
        end
      end else if (c == OP_LOAD) begin
        bus.mem_rd_data = extend(dmem_raw(a), f);
      end
    end
  end

  initial begin
    bus.wb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.wb_ready = wb_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic pop(input int kind, output exp_t e, output bit ok);
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_event", 64'(kind), 64'hFF);
      ok = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    check(e.kind == kind, "event_kind", 64'(kind), 64'(e.kind));
    ok = (e.kind == kind);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    bit          prev_hold;
    logic [31:0] prev_data;
    logic [4:0]  prev_rd;
    exp_t        e;
    bit          ok;
    prev_hold = 1'b0;
    prev_data = 32'd0;
    prev_rd   = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold) begin
        check(bus.wb_valid && bus.wb_data == prev_data && bus.wb_rd == prev_rd, "wb_held_stable",
              {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, prev_rd, prev_data});
      end
      if (bus.store_done) begin
        pop(K_STORE, e, ok);
        if (ok) check(bus.mem_addr == e.addr && bus.mem_wdata == e.data && bus.mem_funct3 == e.f3,
                      "store_port", {bus.mem_funct3, bus.mem_addr, bus.mem_wdata}, {e.f3, e.addr, e.data});
      end
      if (bus.exc_valid) begin
        pop(K_EXC, e, ok);
        if (ok) check(bus.exc_cause == e.cause && bus.exc_addr == e.addr, "exc_info",
                      {bus.exc_cause, bus.exc_addr}, {e.cause, e.addr});
      end
      if (bus.wb_valid && bus.wb_ready) begin
        pop(K_WB, e, ok);
        if (ok) check(bus.wb_rd == e.rd && bus.wb_data == e.data, "wb_value",
                      {bus.wb_rd, bus.wb_data}, {e.rd, e.data});
      end
      prev_hold = bus.wb_valid && !bus.wb_ready;
      prev_data = bus.wb_data;
      prev_rd   = bus.wb_rd;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(1'b0, "in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_addr   = a;
    bus.in_wdata  = wd;
    bus.in_rd     = rd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Issue one op, push its expected result, and check cycle-level latency.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    int         kind;
    logic [1:0] cause;
    exp_t       e;
    bit         ok;
    wait_ready(ok);
    if (!ok) return;
    classify(op, f3, a, kind, cause);
    e.kind = kind; e.rd = rd; e.data = 32'd0; e.cause = cause; e.addr = a; e.f3 = f3;
    case (kind)
      K_WB:    e.data = a;
      K_LOAD:  begin e.kind = K_WB; e.data = extend(ref_raw(a), f3); end
      K_STORE: begin
        e.data = wd;
        for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      end
      default: ;
    endcase
    exp_q.push_back(e);
    drive(op, f3, a, wd, rd);
    @(negedge clk);
    case (kind)
      K_STORE: begin
        check(bus.mem_dp_ctrl == OP_STORE && bus.store_done && !bus.in_ready, "store_cycle1",
              {bus.mem_dp_ctrl, bus.store_done, bus.in_ready}, {OP_STORE, 2'b10});
        @(negedge clk);
        check(bus.mem_dp_ctrl == 7'd0 && !bus.store_done && bus.in_ready, "store_cycle2",
              {bus.mem_dp_ctrl, bus.store_done, bus.in_ready}, {7'd0, 2'b01});
      end
      K_EXC: begin
        check(bus.exc_valid && bus.mem_dp_ctrl == 7'd0 && !bus.wb_valid, "exc_cycle1",
              {bus.exc_valid, bus.mem_dp_ctrl, bus.wb_valid}, {1'b1, 7'd0, 1'b0});
        @(negedge clk);
        check(!bus.exc_valid && bus.mem_dp_ctrl == 7'd0, "exc_cycle2",
              {bus.exc_valid, bus.mem_dp_ctrl}, {1'b0, 7'd0});
      end
      K_LOAD: begin
        check(bus.mem_dp_ctrl == OP_LOAD && !bus.wb_valid, "load_req",
              {bus.mem_dp_ctrl, bus.wb_valid}, {OP_LOAD, 1'b0});
        @(negedge clk);
        check(bus.mem_dp_ctrl == 7'd0 && !bus.wb_valid, "load_cap",
              {bus.mem_dp_ctrl, bus.wb_valid}, {7'd0, 1'b0});
        @(negedge clk);
        check(bus.wb_valid && !bus.in_ready, "load_wb_n3", {bus.wb_valid, bus.in_ready}, 2'b10);
      end
      default: begin
        check(bus.wb_valid && bus.mem_dp_ctrl == 7'd0 && !bus.in_ready, "bypass_wb_n1",
              {bus.wb_valid, bus.mem_dp_ctrl, bus.in_ready}, {1'b1, 7'd0, 1'b0});
      end
    endcase
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < MEM_BYTES; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = 7'd0; bus.in_funct3 = 3'd0;
    bus.in_addr = 32'd0; bus.in_wdata = 32'd0; bus.in_rd = 5'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check(bus.in_ready && bus.mem_dp_ctrl == 7'd0 && !bus.wb_valid && !bus.store_done && !bus.exc_valid,
          "reset_ctrl", {bus.in_ready, bus.mem_dp_ctrl, bus.wb_valid, bus.store_done, bus.exc_valid},
          {1'b1, 7'd0, 3'd0});
    check(bus.wb_data == 32'd0 && bus.mem_addr == 32'd0 && bus.exc_cause == 2'd0 && bus.exc_addr == 32'd0,
          "reset_data", {bus.wb_data, bus.mem_addr}, 64'd0);

    issue(OP_STORE, 3'b010, 32'd8, 32'hDEADBEEF, 5'd0);
    issue(OP_LOAD,  3'b010, 32'd8, 32'd0, 5'd5);
    issue(OP_STORE, 3'b000, 32'd3, 32'h00000080, 5'd0);
    issue(OP_LOAD,  3'b000, 32'd3, 32'd0, 5'd9);
    issue(OP_LOAD,  3'b100, 32'd3, 32'd0, 5'd10);
    issue(OP_LOAD,  3'b010, 32'd6, 32'd0, 5'd1);
    issue(OP_LOAD,  3'b001, 32'd63, 32'd0, 5'd1);
    issue(OP_LOAD,  3'b010, 32'd64, 32'd0, 5'd1);
    issue(OP_STORE, 3'b010, 32'd60, 32'h12345678, 5'd0);
    issue(OP_STORE, 3'b010, 32'd61, 32'h1, 5'd0);
    issue(OP_STORE, 3'b001, 32'd62, 32'hCAFE, 5'd0);
    issue(OP_LOAD,  3'b010, 32'hFFFFFFFC, 32'd0, 5'd2);
    issue(OP_LOAD,  3'b011, 32'd0, 32'd0, 5'd2);
    issue(OP_LOAD,  3'b001, 32'd62, 32'd0, 5'd11);

    // Held writeback: register file stalls for 4 cycles.
    wait_ready(ok);
    @(posedge clk);
    #2 wb_hold = 1'b1; bus.wb_ready = 1'b0;
    issue(7'b0110011, 3'd0, 32'd42, 32'd0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(bus.wb_valid && bus.wb_data == 32'd42 && bus.wb_rd == 5'd7 && !bus.in_ready, "wb_stall",
            {bus.wb_valid, bus.in_ready, bus.wb_rd, bus.wb_data}, {2'b10, 5'd7, 32'd42});
    end
    @(posedge clk);
    #2 wb_hold = 1'b0; bus.wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(!bus.wb_valid && bus.in_ready, "wb_release", {bus.wb_valid, bus.in_ready}, 2'b01);

    // Reset during LOAD_REQ drops the op.
    wait_ready(ok);
    drive(OP_LOAD, 3'b010, 32'd0, 32'd0, 5'd3);
    @(negedge clk);
    check(bus.mem_dp_ctrl == OP_LOAD, "pre_reset_load_req", 64'(bus.mem_dp_ctrl), 64'(OP_LOAD));
    rst_n = 1'b0;
    #1;
    check(bus.mem_dp_ctrl == 7'd0 && bus.in_ready && !bus.wb_valid, "async_reset",
          {bus.mem_dp_ctrl, bus.in_ready, bus.wb_valid}, {7'd0, 2'b10});
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(!bus.wb_valid && !bus.exc_valid, "no_wb_after_reset", {bus.wb_valid, bus.exc_valid}, 2'b00);
    end
    issue(OP_LOAD, 3'b010, 32'd8, 32'd0, 5'd4);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_LOAD;
        1:       op = OP_STORE;
        default: begin
          op = 7'($urandom);
          while (op == OP_LOAD || op == OP_STORE) op = 7'($urandom);
        end
      endcase
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (op == OP_LOAD && $urandom_range(0, 1) == 1 ? 3'b100 : 3'b000);
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
      issue(op, f3, a, $urandom, 5'($urandom));
    end

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
